// File: rtl/ball_sched.sv
// ball_sched: per-frame motion sequencer for three balls with wall and paddle collisions.
// Optional feature macro PAUSE_EN adds a pause input that holds off new sweeps while high.
module ball_sched #(
  parameter int unsigned TOP_MARGIN     = 25,
  parameter int unsigned BOTTOM_EDGE    = 479,
  parameter int unsigned PADDLE_LEN     = 72,
  parameter int unsigned INIT_X         = 316,
  parameter int unsigned INIT_Y0        = 100,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
`ifdef PAUSE_EN
  input  logic       pause,
`endif
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  output logic [9:0] ball_x_0,
  output logic [9:0] ball_x_1,
  output logic [9:0] ball_x_2,
  output logic [9:0] ball_y_0,
  output logic [9:0] ball_y_1,
  output logic [9:0] ball_y_2,
  output logic [3:0] ball_speed,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned PW            = 10;
  localparam int unsigned CW            = 11;
  localparam int unsigned SW            = 4;
  localparam int unsigned HW            = $clog2(HITS_PER_LEVEL + 1);
  localparam int unsigned BALL_SPAN     = 7;
  localparam int unsigned Y_STEP        = 120;
  localparam int unsigned LEFT_HIT_X    = 40;
  localparam int unsigned LEFT_MISS_X   = 32;
  localparam int unsigned LEFT_BOUNCE_X = 41;
  localparam int unsigned RIGHT_HIT_X   = 592;
  localparam int unsigned RIGHT_MISS_X  = 600;
  localparam int unsigned SPEED_INIT    = 2;
  localparam int unsigned SPEED_MAX     = 5;

  localparam logic [2:0][PW-1:0] INIT_XS = {3{PW'(INIT_X)}};
  localparam logic [2:0][PW-1:0] INIT_YS = {PW'(INIT_Y0 + 2 * Y_STEP),
                                            PW'(INIT_Y0 + Y_STEP),
                                            PW'(INIT_Y0)};
  // Bit k is ball k: ball0 right/down, ball1 left/down, ball2 right/up.
  localparam logic [2:0] INIT_RIGHT = 3'b101;
  localparam logic [2:0] INIT_DOWN  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_UPD0,
    S_UPD1,
    S_UPD2,
    S_OVER
  } state_e;

  state_e                state_q;
  logic [2:0][PW-1:0]    bx_q;
  logic [2:0][PW-1:0]    by_q;
  logic [2:0]            right_q;
  logic [2:0]            down_q;
  logic [SW-1:0]         speed_q;
  logic [SW-1:0]         cur_s_q;
  logic [HW-1:0]         hits_q;
  logic                  game_over_q;
  logic                  busy_q;

  logic                  tick_ok;
  logic [1:0]            idx;
  logic [CW-1:0]         step;
  logic [CW-1:0]         x_cur;
  logic [CW-1:0]         y_cur;
  logic [CW-1:0]         p1_top;
  logic [CW-1:0]         p2_top;
  logic                  ov1;
  logic                  ov2;
  logic [CW-1:0]         x_d;
  logic [CW-1:0]         y_d;
  logic                  right_d;
  logic                  down_d;
  logic                  hit;
  logic                  miss;
  logic [HW-1:0]         hits_d;
  logic [SW-1:0]         speed_d;

`ifdef PAUSE_EN
  assign tick_ok = frame_tick & ~pause;
`else
  assign tick_ok = frame_tick;
`endif

  // Ball selected by the current update state.
  always_comb begin
    idx = 2'd0;
    case (state_q)
      S_UPD1:  idx = 2'd1;
      S_UPD2:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
  end

  assign step   = CW'(cur_s_q);
  assign x_cur  = CW'(bx_q[idx]);
  assign y_cur  = CW'(by_q[idx]);
  assign p1_top = CW'(paddle1_y) + CW'(TOP_MARGIN);
  assign p2_top = CW'(paddle2_y) + CW'(TOP_MARGIN);
  assign ov1    = (y_cur + CW'(BALL_SPAN) >= p1_top) && (y_cur <= p1_top + CW'(PADDLE_LEN));
  assign ov2    = (y_cur + CW'(BALL_SPAN) >= p2_top) && (y_cur <= p2_top + CW'(PADDLE_LEN));

  // Vertical motion with top/bottom wall bounce.
  always_comb begin
    y_d    = y_cur;
    down_d = down_q[idx];
    if (down_q[idx]) begin
      if (y_cur + step + CW'(BALL_SPAN) >= CW'(BOTTOM_EDGE)) begin
        y_d    = CW'(BOTTOM_EDGE - BALL_SPAN);
        down_d = 1'b0;
      end else begin
        y_d = y_cur + step;
      end
    end else if (y_cur <= CW'(TOP_MARGIN) + step) begin
      y_d    = CW'(TOP_MARGIN);
      down_d = 1'b1;
    end else begin
      y_d = y_cur - step;
    end
  end

  // Horizontal motion: paddle hit takes priority over a miss.
  always_comb begin
    x_d     = x_cur;
    right_d = right_q[idx];
    hit     = 1'b0;
    miss    = 1'b0;
    if (!right_q[idx]) begin
      if ((x_cur <= CW'(LEFT_HIT_X) + step) && ov1) begin
        x_d     = CW'(LEFT_BOUNCE_X);
        right_d = 1'b1;
        hit     = 1'b1;
      end else if (x_cur < CW'(LEFT_MISS_X) + step) begin
        miss = 1'b1;
      end else begin
        x_d = x_cur - step;
      end
    end else begin
      if ((x_cur + step >= CW'(RIGHT_HIT_X)) && ov2) begin
        x_d     = CW'(RIGHT_HIT_X);
        right_d = 1'b0;
        hit     = 1'b1;
      end else if (x_cur + step > CW'(RIGHT_MISS_X)) begin
        miss = 1'b1;
      end else begin
        x_d = x_cur + step;
      end
    end
  end

  // Hit counting and speed level, saturating at the top level.
  always_comb begin
    hits_d  = hits_q;
    speed_d = speed_q;
    if (hit) begin
      if (hits_q + HW'(1) == HW'(HITS_PER_LEVEL)) begin
        hits_d = '0;
        if (speed_q < SW'(SPEED_MAX)) begin
          speed_d = speed_q + SW'(1);
        end
      end else begin
        hits_d = hits_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bx_q        <= INIT_XS;
      by_q        <= INIT_YS;
      right_q     <= INIT_RIGHT;
      down_q      <= INIT_DOWN;
      speed_q     <= SW'(SPEED_INIT);
      cur_s_q     <= SW'(SPEED_INIT);
      hits_q      <= '0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q     <= S_WAIT;
            bx_q        <= INIT_XS;
            by_q        <= INIT_YS;
            right_q     <= INIT_RIGHT;
            down_q      <= INIT_DOWN;
            speed_q     <= SW'(SPEED_INIT);
            hits_q      <= '0;
            game_over_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (tick_ok) begin
            cur_s_q <= speed_q;
            busy_q  <= 1'b1;
            state_q <= S_UPD0;
          end
        end
        S_UPD0, S_UPD1, S_UPD2: begin
          if (miss) begin
            game_over_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_OVER;
          end else begin
            bx_q[idx]    <= PW'(x_d);
            by_q[idx]    <= PW'(y_d);
            right_q[idx] <= right_d;
            down_q[idx]  <= down_d;
            hits_q       <= hits_d;
            speed_q      <= speed_d;
            if (state_q == S_UPD2) begin
              busy_q  <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              state_q <= (state_q == S_UPD0) ? S_UPD1 : S_UPD2;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ball_x_0   = bx_q[0];
  assign ball_x_1   = bx_q[1];
  assign ball_x_2   = bx_q[2];
  assign ball_y_0   = by_q[0];
  assign ball_y_1   = by_q[1];
  assign ball_y_2   = by_q[2];
  assign ball_speed = speed_q;
  assign game_over  = game_over_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ball_sched.sv
// tb_ball_sched: randomized play against a frame-level game model with a sweep scoreboard.
module tb_ball_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle1_y = 10'd0;
  logic [9:0] paddle2_y = 10'd0;
`ifdef PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [9:0] ball_x_0, ball_x_1, ball_x_2;
  logic [9:0] ball_y_0, ball_y_1, ball_y_2;
  logic [3:0] ball_speed;
  logic       game_over;
  logic       busy;

  ball_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_tick (frame_tick),
`ifdef PAUSE_EN
    .pause      (pause),
`endif
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .ball_x_0   (ball_x_0),
    .ball_x_1   (ball_x_1),
    .ball_x_2   (ball_x_2),
    .ball_y_0   (ball_y_0),
    .ball_y_1   (ball_y_1),
    .ball_y_2   (ball_y_2),
    .ball_speed (ball_speed),
    .game_over  (game_over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Game model: positions, directions (+1/-1), speed, hits, mode 0=idle 1=play 2=over.
  int mx[3], my[3], mdr[3], mdd[3];
  int mspd, mhits, mmode;

  typedef struct packed {
    int x0; int x1; int x2;
    int y0; int y1; int y2;
    int spd; int go; int len;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void m_init();
    for (int k = 0; k < 3; k++) begin
      mx[k] = 316;
      my[k] = 100 + 120 * k;
    end
    mdr   = '{1, -1, 1};
    mdd   = '{1, 1, -1};
    mspd  = 2;
    mhits = 0;
  endfunction

  // One frame of play; returns the number of cycles busy stays high.
  function automatic int m_sweep(int p1, int p2);
    int s, x, y, nx, ny, ndr, ndd;
    bit hit, miss, ov1, ov2;
    s = mspd;
    for (int k = 0; k < 3; k++) begin
      x = mx[k]; y = my[k];
      hit = 0; miss = 0; nx = x; ndr = mdr[k]; ndd = mdd[k];
      if (mdd[k] > 0) begin
        if (y + s + 7 >= 479) begin ny = 472; ndd = -1; end
        else ny = y + s;
      end else begin
        if (y <= 25 + s) begin ny = 25; ndd = 1; end
        else ny = y - s;
      end
      ov1 = (y + 7 >= p1 + 25) && (y <= p1 + 25 + 72);
      ov2 = (y + 7 >= p2 + 25) && (y <= p2 + 25 + 72);
      if (mdr[k] < 0) begin
        if (x <= 40 + s && ov1) begin nx = 41; ndr = 1; hit = 1; end
        else if (x < 32 + s) miss = 1;
        else nx = x - s;
      end else begin
        if (x + s >= 592 && ov2) begin nx = 592; ndr = -1; hit = 1; end
        else if (x + s > 600) miss = 1;
        else nx = x + s;
      end
      if (miss) begin
        mmode = 2;
        return k + 1;
      end
      mx[k] = nx; my[k] = ny; mdr[k] = ndr; mdd[k] = ndd;
      if (hit) begin
        mhits++;
        if (mhits == 4) begin
          mhits = 0;
          if (mspd < 5) mspd++;
        end
      end
    end
    return 3;
  endfunction

  function automatic exp_t snap(int len);
    exp_t e;
    e.x0 = mx[0]; e.x1 = mx[1]; e.x2 = mx[2];
    e.y0 = my[0]; e.y1 = my[1]; e.y2 = my[2];
    e.spd = mspd; e.go = (mmode == 2) ? 1 : 0; e.len = len;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_snap(input string tag, input exp_t e);
    check({tag, "_x0"}, int'(ball_x_0), e.x0);
    check({tag, "_x1"}, int'(ball_x_1), e.x1);
    check({tag, "_x2"}, int'(ball_x_2), e.x2);
    check({tag, "_y0"}, int'(ball_y_0), e.y0);
    check({tag, "_y1"}, int'(ball_y_1), e.y1);
    check({tag, "_y2"}, int'(ball_y_2), e.y2);
    check({tag, "_speed"}, int'(ball_speed), e.spd);
    check({tag, "_game_over"}, int'(game_over), e.go);
  endtask

  task automatic check_now(input string tag);
    check_snap(tag, snap(0));
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: each falling edge of busy closes one sweep and is scored.
  int blen = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy) begin
      blen++;
    end else if (prev_busy) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_sweep", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("sweep_len", blen, mon_e.len);
        check_snap("sweep", mon_e);
      end
      blen = 0;
    end
    prev_busy = busy;
  end

  task automatic pulse_tick();
    int  len;
    bool_mode_t_dummy: begin end
    len = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    if (mmode == 1) begin
      len = m_sweep(int'(paddle1_y), int'(paddle2_y));
      sbq.push_back(snap(len));
      repeat (4) @(posedge clk);
      #1;
    end else begin
      repeat (4) @(posedge clk);
      #1;
      check_now("ignored_tick");
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (mmode != 1) begin
      m_init();
      mmode = 1;
    end
    @(negedge clk);
    check_now("start");
  endtask

  // Paddle target: most urgent ball heading toward that side, with random slack.
  function automatic int pick(int dir);
    int best, p;
    best = -1;
    for (int k = 0; k < 3; k++) begin
      if (mdr[k] == dir) begin
        if (best < 0) best = k;
        else if (dir > 0 && mx[k] > mx[best]) best = k;
        else if (dir < 0 && mx[k] < mx[best]) best = k;
      end
    end
    if (best < 0) return int'($urandom_range(0, 400));
    p = my[best] - int'($urandom_range(18, 97));
    if (p < 0) p = 0;
    return p;
  endfunction

  task automatic set_paddles();
    int r;
    r = int'($urandom_range(0, 31));
    paddle1_y = 10'(pick(-1));
    paddle2_y = 10'(pick(1));
    if (r == 0) paddle1_y = 10'($urandom_range(0, 400));
    if (r == 1) paddle2_y = 10'($urandom_range(0, 400));
  endtask

  initial begin
    mmode = 0;
    m_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_now("reset");
    check("reset_x0_const", int'(ball_x_0), 316);
    check("reset_y1_const", int'(ball_y_1), 220);
    check("reset_y2_const", int'(ball_y_2), 340);
    @(posedge clk); #1 rst_n = 1'b1;

    pulse_tick();
    pulse_start();
    paddle1_y = 10'd0;
    paddle2_y = 10'd0;
    pulse_tick();
    check("first_x0", int'(ball_x_0), 318);
    check("first_y0", int'(ball_y_0), 102);
    check("first_x1", int'(ball_x_1), 314);
    check("first_y1", int'(ball_y_1), 222);
    check("first_x2", int'(ball_x_2), 318);
    check("first_y2", int'(ball_y_2), 338);

    for (int f = 0; f < 1400; f++) begin
      if (mmode == 2) begin
        if ($urandom_range(0, 1) == 1) pulse_tick();
        pulse_start();
      end
      set_paddles();
      if ($urandom_range(0, 31) == 0) pulse_start();
      pulse_tick();
    end

    // Reset asserted in the middle of a sweep.
    if (mmode != 1) pulse_start();
    set_paddles();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    m_init();
    mmode = 0;
    sbq.push_back(snap(1));
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_now("rst_mid_sweep");
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_tick();
    pulse_start();
    set_paddles();
    pulse_tick();

    repeat (4) @(posedge clk);
    check("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
